// File: rtl/div_radix2_pkg.sv
// Shared defines for the integer execute unit: ALU control codes plus the
// divider's datapath width, counter width and FSM state encoding.
// Optional feature macro: DIV_ZERO_FAST_EN. When it is defined, a divide by
// zero finishes in one cycle instead of running the full iterative path.
package div_radix2_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_STEP = 6'd31;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_DIV  = 4'd10,
        ALU_DIVU = 4'd11
    } alu_ctrl_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [DIV_DATA_W-1:0] cond_neg(input logic [DIV_DATA_W-1:0] x,
                                                       input logic neg);
        return neg ? (~x + {{(DIV_DATA_W-1){1'b0}}, 1'b1}) : x;
    endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not
// borrow. The quotient bit is the inverted borrow.
module div_step
    import div_radix2_pkg::*;
(
    input  logic [DIV_DATA_W-1:0] rem_in,
    input  logic                  bit_in,
    input  logic [DIV_DATA_W-1:0] divisor,
    output logic [DIV_DATA_W-1:0] rem_out,
    output logic                  q_bit
);

    logic [DIV_DATA_W:0] shifted;
    logic [DIV_DATA_W:0] diff;

    // Trial subtract on a 33-bit window so the borrow lands in the top bit.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[DIV_DATA_W];
        rem_out = q_bit ? diff[DIV_DATA_W-1:0] : shifted[DIV_DATA_W-1:0];
    end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for the EX stage: one quotient bit per
// cycle, signed (DIV) and unsigned (DIVU), result = {remainder, quotient}.
// Handshake: the EX stage holds valid high until it consumes the result; the
// unit stalls the pipe while it is being asked (IDLE & valid) or computing
// (BUSY), presents ready in DONE, and returns to IDLE on ex_adv. flush aborts
// from any state and wins over valid and ex_adv.
// Optional macro: DIV_ZERO_FAST_EN -- divide by zero goes IDLE -> DONE directly.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                valid,
    input  logic                sign,
    input  logic                ex_adv,
    output logic                div_stall,
    output logic                ready,
    output logic [2*DATA_W-1:0] result
);

    div_state_t           state;
    logic [DIV_CNT_W-1:0] cnt;
    logic [DATA_W-1:0]    rem_r;
    logic [DATA_W-1:0]    quo_r;
    logic [DATA_W-1:0]    dvs_r;
    logic                 neg_q;
    logic                 neg_r;
    logic [2*DATA_W-1:0]  res_r;
    logic                 ready_r;

    logic [DATA_W-1:0]    rem_nxt;
    logic [DATA_W-1:0]    quo_nxt;
    logic                 q_bit;
    logic                 sa;
    logic                 sb;
    logic                 b_zero;
    logic                 fast_zero;

    // quo_r starts as |a| and shifts left; dividend bits leave the top while
    // quotient bits enter the bottom, so after 32 steps it holds the quotient.
    div_step u_step (
        .rem_in  (rem_r),
        .bit_in  (quo_r[DATA_W-1]),
        .divisor (dvs_r),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign quo_nxt = {quo_r[DATA_W-2:0], q_bit};
    assign sa      = sign & a[DATA_W-1];
    assign sb      = sign & b[DATA_W-1];
    assign b_zero  = (b == '0);

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = b_zero;
`else
    assign fast_zero = 1'b0;
`endif

    // Divider FSM: capture, 32 restoring steps, then hold the result until consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            res_r   <= '0;
            ready_r <= 1'b0;
        end else if (flush) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (valid) begin
                        if (fast_zero) begin
                            // Same value the full path produces for b == 0.
                            res_r   <= {a, {DATA_W{1'b1}}};
                            ready_r <= 1'b1;
                            state   <= DIV_DONE;
                        end else begin
                            rem_r <= '0;
                            quo_r <= cond_neg(a, sa);
                            dvs_r <= cond_neg(b, sb);
                            // A zero divisor yields all-ones quotient and the
                            // dividend as remainder; only the remainder keeps a's sign.
                            neg_q <= (sa ^ sb) & ~b_zero;
                            neg_r <= sa;
                            cnt   <= '0;
                            state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == DIV_LAST_STEP) begin
                        res_r   <= {cond_neg(rem_nxt, neg_r), cond_neg(quo_nxt, neg_q)};
                        ready_r <= 1'b1;
                        state   <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ex_adv) begin
                        ready_r <= 1'b0;
                        state   <= DIV_IDLE;
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    state   <= DIV_IDLE;
                end
            endcase
        end
    end

    // Stall while a divide is being requested or computed; never during reset or flush.
    always_comb begin
        div_stall = rst & ~flush &
                    (((state == DIV_IDLE) & valid) | (state == DIV_BUSY));
    end

    assign ready  = ready_r;
    assign result = res_r;

endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of current operation.
REQ-005 SHALL have port a  input  32  dividend.
REQ-006 SHALL have port b  input  32  divisor.
REQ-007 SHALL have port valid  input  1  divide requested, held high by EX stage until consumed.
REQ-008 SHALL have port sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-009 SHALL have port ex_adv  input  1  EX stage advances this cycle (result consumed).
REQ-010 SHALL have port div_stall  output  1  pipeline stall request.
REQ-011 SHALL have port ready  output  1  result valid.
REQ-012 SHALL have port result  output  64  {remainder[31:0], quotient[31:0]} (hi, lo).

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; radix-2 restoring division, one quotient bit per cycle.
REQ-014 IDLE & valid & ~flush SHALL capture |a|, |b|, sign, sign(a), sign(b) (magnitudes by two's-complement when sign=1), clear 6-bit counter, go BUSY.
REQ-015 BUSY SHALL perform one shift/trial-subtract step per cycle; after exactly 32 steps SHALL go DONE.
REQ-016 On BUSY->DONE, quotient SHALL be negated if sign & (sign(a)^sign(b)); remainder SHALL be negated if sign & sign(a).
REQ-017 div_stall SHALL equal ~flush & ((IDLE & valid) | BUSY); low in DONE; first valid cycle to DONE = 33 stalled cycles.
REQ-018 ready SHALL be 1 only in DONE; result SHALL be held constant throughout DONE.
REQ-019 DONE & ex_adv SHALL go IDLE; DONE & ~ex_adv SHALL stay DONE regardless of valid.
REQ-020 A new divide SHALL NOT start from DONE; back-to-back divides start from IDLE the cycle after ex_adv.
REQ-021 flush in any state SHALL force IDLE next edge, discard partial result, ready=0 next cycle; flush wins over valid and ex_adv.
REQ-022 b==0 SHALL yield quotient 0xFFFFFFFF, remainder = a, for both signs.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-024 Operand changes on a/b/sign after capture SHALL NOT affect the result.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, counter 0, result 0, ready 0; div_stall SHALL be 0 while rst low.
REQ-026 Reset mid-BUSY SHALL abandon the operation; after release, behaviour matches power-on.

Configuration
REQ-027 Macro DIV_ZERO_FAST_EN defined: IDLE with b==0 SHALL go directly to DONE with REQ-022 result, div_stall high for 1 cycle only.
REQ-028 DIV_ZERO_FAST_EN undefined: b==0 SHALL take the full 32-step path, same result value.

Structure
REQ-029 State encoding, DATA_W, counter width SHALL live in the shared defines header beside the ALU control codes.
REQ-030 One sub-module div_step (combinational single restoring step: partial remainder, divisor in -> next remainder, quotient bit out) SHALL be used.

Verification
REQ-031 Unsigned 100/7 -> 33 stall cycles, then ready=1, result={0x00000002,0x0000000E}.
REQ-032 Signed -7/2 -> result={0xFFFFFFFF,0xFFFFFFFD}; signed 7/-2 -> {0x00000001,0xFFFFFFFD}.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}; 5/0 -> {0x00000005,0xFFFFFFFF}, 1 stall cycle with macro, 33 without.
REQ-034 flush at BUSY step 10 -> div_stall 0 that cycle, IDLE next; subsequent 9/3 -> {0,3}, full latency.
REQ-035 Two back-to-back divides, ex_adv low 3 extra cycles in first DONE -> result held, second starts cycle after ex_adv, both correct.
REQ-036 rst asserted mid-BUSY -> outputs 0 immediately; after release, 20/6 -> {2,3}.
